fpm_result_buffer: RTL and testbench

FPM_RESULT_BUFFER -- requirements
Module: fpm_result_buffer

---
 rtl/fpm_pkg.sv | 27 ++
 rtl/fpm_sync_fifo.sv | 75 +++++++
 rtl/fpm_result_buffer.sv | 100 ++++++++++
 tb/tb_fpm_result_buffer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fpm_pkg.sv
// ---------------------------------------------------------------------------
// fpm_pkg : shared constants and helpers for the FPM result buffer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fpm_pkg;

  localparam int FPM_LATENCY          = 11;
  localparam int FPM_DEPTH            = 4;
  localparam int FPM_DATA_W           = 32;
  localparam int FPM_FLAG_W           = 2;
  localparam int FPM_FLAG_ZERO_BIT    = 0;
  localparam int FPM_FLAG_INF_NAN_BIT = 1;

  // Classifies a single-precision result from its biased exponent field.
  function automatic logic [FPM_FLAG_W-1:0] fpm_special_flags(input logic [7:0] exponent);
    logic [FPM_FLAG_W-1:0] flags;
    flags                       = '0;
    flags[FPM_FLAG_ZERO_BIT]    = (exponent == 8'h00);
    flags[FPM_FLAG_INF_NAN_BIT] = (exponent == 8'hFF);
    return flags;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpm_sync_fifo.sv
// ---------------------------------------------------------------------------
// fpm_sync_fifo : single-clock FIFO, power-of-two depth, registered head
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpm_sync_fifo
  import fpm_pkg::*;
#(
  parameter int WIDTH = FPM_DATA_W,
  parameter int DEPTH = FPM_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap naturally because DEPTH is a power of two; count tells full from empty.
  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && (count_q == CW'(DEPTH))));

endmodule

`default_nettype wire

// File: rtl/fpm_result_buffer.sv
// ---------------------------------------------------------------------------
// fpm_result_buffer : credit-tracked capture FIFO for fixed-latency FPM results
// Optional feature macro: FPM_SPECIAL_CASE_EN (adds per-entry out_flags)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fpm_result_buffer
  import fpm_pkg::*;
#(
  parameter int LATENCY = FPM_LATENCY,
  parameter int DEPTH   = FPM_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FPM_DATA_W-1:0]        SUM,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FPM_DATA_W-1:0]        out_data,
`ifdef FPM_SPECIAL_CASE_EN
  output logic [FPM_FLAG_W-1:0]        out_flags,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int IW = $clog2(LATENCY+1);
`ifdef FPM_SPECIAL_CASE_EN
  localparam int FW = FPM_DATA_W + FPM_FLAG_W;
`else
  localparam int FW = FPM_DATA_W;
`endif

  logic [LATENCY-1:0] tag_q, tag_d;
  logic [IW-1:0]      inflight_q, inflight_d;
  logic               issue;
  logic               push;
  logic [FW-1:0]      push_word;
  logic [FW-1:0]      head_word;

  assign issue = in_valid & in_ready;
  assign push  = tag_q[LATENCY-1];

  generate
    if (LATENCY > 1) begin : g_tag_shift
      assign tag_d = {tag_q[LATENCY-2:0], issue};
    end else begin : g_tag_single
      assign tag_d = issue;
    end
  endgenerate

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, push})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

  // Every outstanding product already owns a FIFO slot, so a push can never meet a full FIFO.
  assign in_ready = (32'(count) + 32'(inflight_q)) < 32'(DEPTH);

`ifdef FPM_SPECIAL_CASE_EN
  assign push_word = {fpm_special_flags(SUM[30:23]), SUM};
  assign out_data  = head_word[FPM_DATA_W-1:0];
  assign out_flags = head_word[FW-1:FPM_DATA_W];
`else
  assign push_word = SUM;
  assign out_data  = head_word;
`endif

  fpm_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_word),
    .pop_i       (out_ready),
    .head_o      (head_word),
    .valid_o     (out_valid),
    .count_o     (count)
  );

endmodule

`default_nettype wire

// File: tb/tb_fpm_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_fpm_result_buffer : directed + randomized bench with an issue-order model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fpm_result_buffer;
  import fpm_pkg::*;

  localparam int LAT = FPM_LATENCY;
  localparam int DEP = FPM_DEPTH;
  localparam int CW  = $clog2(DEP+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   SUM = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_data;
  logic [CW-1:0] count;
`ifdef FPM_SPECIAL_CASE_EN
  logic [1:0]    out_flags;
`endif

  always #5 clk = ~clk;

  fpm_result_buffer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SUM       (SUM),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef FPM_SPECIAL_CASE_EN
    .out_flags (out_flags),
`endif
    .count     (count)
  );

  // Model: each accepted issue returns its product LAT cycles later and is
  // visible at the FIFO head from cycle issue+LAT+1 until popped, in issue order.
  typedef struct {
    logic [31:0] word;
    int          vis;
  } res_t;

  res_t        mq[$];
  logic [31:0] fpm_ret [int];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          just_reset = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] pick_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7F80_0000;
      2:       return 32'h40C0_0000;
      3:       return 32'h7FC0_0001;
      default: return $urandom();
    endcase
  endfunction

  task automatic do_cycle(input bit iv, input bit ordy, input bit rst);
    int          n_vis = 0;
    int          n_fly = 0;
    bit          exp_rdy;
    logic [31:0] w;
    res_t        r;
    in_valid  = iv;
    out_ready = ordy;
    rst_n     = !rst;
    SUM       = fpm_ret.exists(cyc) ? fpm_ret[cyc] : $urandom();
    foreach (mq[i]) begin
      if (mq[i].vis <= cyc) n_vis++;
      else n_fly++;
    end
    exp_rdy = (n_vis + n_fly) < DEP;
    @(negedge clk);
    if (!rst) begin
      check_eq("in_ready", in_ready, exp_rdy);
      check_eq("out_valid", out_valid, n_vis > 0);
      check_eq("count", count, n_vis);
      if (n_vis > 0) begin
        check_eq("out_data", out_data, mq[0].word);
`ifdef FPM_SPECIAL_CASE_EN
        check_eq("out_flags", out_flags,
                 {mq[0].word[30:23] == 8'hFF, mq[0].word[30:23] == 8'h00});
`endif
      end else if (just_reset) begin
        check_eq("out_data_rst", out_data, 32'h0);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (ordy && n_vis > 0) void'(mq.pop_front());
      if (iv && exp_rdy) begin
        w = pick_word();
        fpm_ret[cyc + LAT] = w;
        r.word = w;
        r.vis  = cyc + LAT + 1;
        mq.push_back(r);
      end
    end
    cyc++;
  endtask

  initial begin
    repeat (2) do_cycle(1'b0, 1'b0, 1'b1);
    // single issue, consumer always ready
    do_cycle(1'b1, 1'b1, 1'b0);
    repeat (15) do_cycle(1'b0, 1'b1, 1'b0);
    // fill with consumer stalled, release one slot, refill
    repeat (20) do_cycle(1'b1, 1'b0, 1'b0);
    do_cycle(1'b1, 1'b1, 1'b0);
    repeat (15) do_cycle(1'b1, 1'b0, 1'b0);
    repeat (20) do_cycle(1'b0, 1'b1, 1'b0);
    // back-to-back streaming
    repeat (110) do_cycle(1'b1, 1'b1, 1'b0);
    repeat (15) do_cycle(1'b0, 1'b1, 1'b0);
    // reset with products still in flight
    repeat (3) do_cycle(1'b1, 1'b1, 1'b0);
    repeat (2) do_cycle(1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1);
    repeat (15) do_cycle(1'b0, 1'b1, 1'b0);
    // randomized traffic, occasional reset
    repeat (2000) do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                           $urandom_range(0, 199) == 0);
    repeat (1000) do_cycle($urandom_range(0, 1) != 0, $urandom_range(0, 3) == 0,
                           $urandom_range(0, 299) == 0);
    repeat (20) do_cycle(1'b0, 1'b1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
